maple_xfer_sequencer: RTL and testbench

- Register-mapped control and sequencing block for the Maple bus.
- Sits between the SPI register-access front end and the Maple output controller, TX FIFO and receiver.
- Replaces software-driven start/end triggering with a hardware transaction FSM: GO → start pattern → drain FIFO → end pattern → optional response wait with timeout.
- Adds parametrised port count, sticky status with write-1-to-clear, abort, and an interrupt output.

---
 rtl/maple_xfer_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_maple_xfer_sequencer.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maple_xfer_sequencer.sv
// Maple bus transfer sequencer: register file plus a hardware transaction FSM
// (start pattern, FIFO drain, end pattern, optional response wait) with sticky status and IRQ.
module maple_xfer_sequencer #(
  parameter logic [7:0] VERSION       = 8'hA7,
  parameter logic [7:0] CLOCKDIV_INIT = 8'h06,
  parameter int         NUM_PORTS     = 4,
  parameter int         PORT_W        = 2,
  parameter int         TO_SHIFT      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        regnum,
  input  logic [7:0]        regdata_write,
  input  logic              reg_write,
  output logic [7:0]        regdata_read,
  input  logic              tick,
  output logic [7:0]        clock_div,
  output logic [PORT_W-1:0] port_select,
  output logic              trigger_start,
  output logic              trigger_end,
  input  logic              start_active,
  input  logic              end_active,
  input  logic              oe,
  input  logic              tx_avail,
  output logic              tx_flush,
  output logic              rx_arm,
  input  logic              rx_done,
  output logic              busy,
  output logic              irq
);
  localparam int CNT_W = 8 + TO_SHIFT;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_END, S_RXWAIT} state_t;

  state_t            r_state, w_state_nx;
  logic              r_seen, w_seen_nx;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nx, w_load;
  logic              r_trig_start, r_trig_end, r_flush, r_irq, r_rx_en;
  logic              w_trig_start_nx, w_trig_end_nx, w_rx_en_nx;
  logic [2:0]        w_set, w_clr;
  logic [7:0]        r_scratch, r_clkdiv, r_timeout;
  logic [PORT_W-1:0] r_portsel;
  logic [2:0]        r_status, r_irqen;
  logic              w_wr_ctrl, w_go, w_abort, w_busy, w_portsel_ok;

  assign w_wr_ctrl    = reg_write && (regnum == 7'd4);
  assign w_go         = w_wr_ctrl && regdata_write[0];
  assign w_abort      = w_wr_ctrl && regdata_write[1];
  assign w_busy       = (r_state != S_IDLE);
  assign w_load       = CNT_W'(r_timeout) << TO_SHIFT;
  assign w_clr        = (reg_write && regnum == 7'd5) ? regdata_write[2:0] : 3'b000;
  assign w_portsel_ok = !w_busy && ({1'b0, regdata_write} < 9'(NUM_PORTS));

  // A zero load count means wait forever: the counter only runs while non-zero
  always_comb begin
    w_state_nx      = r_state;
    w_seen_nx       = r_seen;
    w_cnt_nx        = r_cnt;
    w_trig_start_nx = 1'b0;
    w_trig_end_nx   = 1'b0;
    w_rx_en_nx      = r_rx_en;
    w_set           = 3'b000;
    if (w_abort) begin
      if (w_busy) w_set[2] = 1'b1;
      w_state_nx = S_IDLE;
      w_seen_nx  = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_go && tx_avail) begin
            w_state_nx      = S_START;
            w_trig_start_nx = 1'b1;
            w_seen_nx       = 1'b0;
            w_rx_en_nx      = regdata_write[2];
          end
        end
        S_START: begin
          if (r_seen && !start_active) begin
            w_state_nx = S_DATA;
            w_seen_nx  = 1'b0;
          end else if (start_active) begin
            w_seen_nx = 1'b1;
          end
        end
        S_DATA: begin
          if (!tx_avail && !oe) begin
            w_state_nx    = S_END;
            w_trig_end_nx = 1'b1;
            w_seen_nx     = 1'b0;
          end
        end
        S_END: begin
          if (r_seen && !end_active) begin
            w_seen_nx = 1'b0;
            if (r_rx_en) begin
              w_state_nx = S_RXWAIT;
              w_cnt_nx   = w_load;
            end else begin
              w_state_nx = S_IDLE;
              w_set[0]   = 1'b1;
            end
          end else if (end_active) begin
            w_seen_nx = 1'b1;
          end
        end
        S_RXWAIT: begin
          if (rx_done) begin
            w_state_nx = S_IDLE;
            w_set[0]   = 1'b1;
          end else if (tick && (r_cnt != '0)) begin
            w_cnt_nx = r_cnt - 1'b1;
            if (r_cnt == CNT_W'(1)) begin
              w_state_nx = S_IDLE;
              w_set[1]   = 1'b1;
            end
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_seen       <= 1'b0;
      r_cnt        <= '0;
      r_trig_start <= 1'b0;
      r_trig_end   <= 1'b0;
      r_flush      <= 1'b0;
      r_rx_en      <= 1'b0;
      r_status     <= 3'b000;
      r_irq        <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_seen       <= w_seen_nx;
      r_cnt        <= w_cnt_nx;
      r_trig_start <= w_trig_start_nx;
      r_trig_end   <= w_trig_end_nx;
      r_flush      <= w_abort;
      r_rx_en      <= w_rx_en_nx;
      r_status     <= (r_status & ~w_clr) | w_set;
      r_irq        <= |(r_status & r_irqen);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scratch <= 8'h00;
      r_clkdiv  <= CLOCKDIV_INIT;
      r_portsel <= '0;
      r_timeout <= 8'hFF;
      r_irqen   <= 3'b000;
    end else if (reg_write) begin
      case (regnum)
        7'd1: r_scratch <= regdata_write;
        7'd2: r_clkdiv  <= regdata_write;
        7'd3: if (w_portsel_ok) r_portsel <= regdata_write[PORT_W-1:0];
        7'd6: r_timeout <= regdata_write;
        7'd7: r_irqen   <= regdata_write[2:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    regdata_read = 8'hFF;
    case (regnum)
      7'd0: regdata_read = VERSION;
      7'd1: regdata_read = r_scratch;
      7'd2: regdata_read = r_clkdiv;
      7'd3: regdata_read = 8'(r_portsel);
      7'd4: regdata_read = {4'b0000, oe, r_rx_en, w_busy, 1'b0};
      7'd5: regdata_read = {5'b00000, r_status};
      7'd6: regdata_read = r_timeout;
      7'd7: regdata_read = {5'b00000, r_irqen};
      default: regdata_read = 8'hFF;
    endcase
  end

  assign clock_div     = r_clkdiv;
  assign port_select   = r_portsel;
  assign trigger_start = r_trig_start;
  assign trigger_end   = r_trig_end;
  assign tx_flush      = r_flush;
  assign rx_arm        = (r_state == S_RXWAIT);
  assign busy          = w_busy;
  assign irq           = r_irq;

endmodule

// File: tb/tb_maple_xfer_sequencer.sv
// Bench for maple_xfer_sequencer: emulated output controller/FIFO, transaction-level
// reference model compared every cycle, plus directed scenarios with literal expectations.
module tb_maple_xfer_sequencer;
  localparam int NUM_PORTS = 4;

  logic       clk, rst, reg_write, tick, start_active, end_active, oe, tx_avail, rx_done;
  logic [6:0] regnum;
  logic [7:0] regdata_write, regdata_read, clock_div;
  logic [1:0] port_select;
  logic       trigger_start, trigger_end, tx_flush, rx_arm, busy, irq;

  int checks = 0;
  int errors = 0;

  maple_xfer_sequencer dut (
    .clk(clk), .rst(rst), .regnum(regnum), .regdata_write(regdata_write),
    .reg_write(reg_write), .regdata_read(regdata_read), .tick(tick),
    .clock_div(clock_div), .port_select(port_select), .trigger_start(trigger_start),
    .trigger_end(trigger_end), .start_active(start_active), .end_active(end_active),
    .oe(oe), .tx_avail(tx_avail), .tx_flush(tx_flush), .rx_arm(rx_arm),
    .rx_done(rx_done), .busy(busy), .irq(irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not end, got running required finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h required %h", nm, $time, got, exp);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  logic [7:0] m_scratch, m_clkdiv, m_timeout;
  logic [1:0] m_portsel;
  logic [2:0] m_status, m_irqen;
  logic       m_rx_en, m_seen, m_ts, m_te, m_fl, m_irq;
  int         m_phase, m_ticks, m_limit; // phase: 0 idle,1 start,2 data,3 end,4 wait
  bit         chk_en = 1'b0;

  task automatic model_step();
    logic go, ab, was_busy, irq_n;
    logic [2:0] set, clr;
    if (rst) begin
      m_scratch = 8'h00; m_clkdiv = 8'h06; m_timeout = 8'hFF; m_portsel = 2'd0;
      m_status = 3'b0; m_irqen = 3'b0; m_rx_en = 1'b0; m_seen = 1'b0;
      m_ts = 1'b0; m_te = 1'b0; m_fl = 1'b0; m_irq = 1'b0;
      m_phase = 0; m_ticks = 0; m_limit = 0;
      chk_en = 1'b1;
      return;
    end
    irq_n    = |(m_status & m_irqen);
    go       = reg_write && regnum == 7'd4 && regdata_write[0];
    ab       = reg_write && regnum == 7'd4 && regdata_write[1];
    was_busy = (m_phase != 0);
    set = 3'b0; clr = 3'b0;
    m_ts = 1'b0; m_te = 1'b0; m_fl = ab;
    if (ab) begin
      if (was_busy) set[2] = 1'b1;
      m_phase = 0;
    end else begin
      case (m_phase)
        0: if (go && tx_avail) begin
             m_phase = 1; m_ts = 1'b1; m_seen = 1'b0; m_rx_en = regdata_write[2];
           end
        1: if (start_active) m_seen = 1'b1;
           else if (m_seen) m_phase = 2;
        2: if (!tx_avail && !oe) begin m_phase = 3; m_te = 1'b1; m_seen = 1'b0; end
        3: if (end_active) m_seen = 1'b1;
           else if (m_seen) begin
             if (m_rx_en) begin m_phase = 4; m_limit = int'(m_timeout) * 16; m_ticks = 0; end
             else begin m_phase = 0; set[0] = 1'b1; end
           end
        default: if (rx_done) begin m_phase = 0; set[0] = 1'b1; end
           else if (tick && m_limit != 0) begin
             m_ticks++;
             if (m_ticks == m_limit) begin m_phase = 0; set[1] = 1'b1; end
           end
      endcase
    end
    if (reg_write) begin
      case (regnum)
        7'd1: m_scratch = regdata_write;
        7'd2: m_clkdiv  = regdata_write;
        7'd3: if (!was_busy && int'(regdata_write) < NUM_PORTS) m_portsel = regdata_write[1:0];
        7'd5: clr = regdata_write[2:0];
        7'd6: m_timeout = regdata_write;
        7'd7: m_irqen = regdata_write[2:0];
        default: ;
      endcase
    end
    m_status = (m_status & ~clr) | set;
    m_irq    = irq_n;
  endtask

  function automatic logic [7:0] m_read(input logic [6:0] a, input logic o);
    case (a)
      7'd0: return 8'hA7;
      7'd1: return m_scratch;
      7'd2: return m_clkdiv;
      7'd3: return {6'b0, m_portsel};
      7'd4: return {4'b0, o, m_rx_en, (m_phase != 0), 1'b0};
      7'd5: return {5'b0, m_status};
      7'd6: return m_timeout;
      7'd7: return {5'b0, m_irqen};
      default: return 8'hFF;
    endcase
  endfunction

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("busy",          8'(busy),          8'(m_phase != 0));
      chk("rx_arm",        8'(rx_arm),        8'(m_phase == 4));
      chk("trigger_start", 8'(trigger_start), 8'(m_ts));
      chk("trigger_end",   8'(trigger_end),   8'(m_te));
      chk("tx_flush",      8'(tx_flush),      8'(m_fl));
      chk("irq",           8'(irq),           8'(m_irq));
      chk("clock_div",     clock_div,         m_clkdiv);
      chk("port_select",   8'(port_select),   8'(m_portsel));
      chk("regdata_read",  regdata_read,      m_read(regnum, oe));
    end
  end

  // ---------------- output controller / TX FIFO emulation ----------------
  initial begin : env
    int st_dly, st_len, en_dly, en_len, tail, fifo;
    bit sending, st_run;
    start_active = 1'b0; end_active = 1'b0; oe = 1'b0; tx_avail = 1'b0;
    st_dly = 0; st_len = 0; en_dly = 0; en_len = 0; tail = 0; fifo = 0;
    sending = 1'b0; st_run = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        st_dly = 0; st_len = 0; en_dly = 0; en_len = 0; tail = 0; fifo = 0;
        sending = 1'b0; st_run = 1'b0;
        start_active = 1'b0; end_active = 1'b0; oe = 1'b0; tx_avail = 1'b0;
      end else begin
        if (trigger_start) begin
          st_dly = int'($urandom % 3); st_len = 1 + int'($urandom % 3); st_run = 1'b1; sending = 1'b0;
        end
        if (trigger_end) begin en_dly = int'($urandom % 3); en_len = 1 + int'($urandom % 3); end
        start_active = 1'b0;
        if (st_run) begin
          if (st_dly > 0) st_dly--;
          else if (st_len > 0) begin start_active = 1'b1; st_len--; end
          else begin st_run = 1'b0; sending = 1'b1; tail = int'($urandom % 3); end
        end
        end_active = 1'b0;
        if (en_dly > 0) en_dly--;
        else if (en_len > 0) begin end_active = 1'b1; en_len--; end
        if (sending) begin
          if (fifo > 0) begin if ($urandom % 2 == 0) fifo--; end
          else if (tail > 0) tail--;
          else sending = 1'b0;
        end
        if (!busy && !sending && !st_run && fifo == 0 && $urandom % 4 == 0)
          fifo = 1 + int'($urandom % 3);
        if (tx_flush) fifo = 0;
        oe       = sending;
        tx_avail = (fifo > 0);
      end
    end
  end

  // ---------------- main stimulus ----------------
  task automatic cyc();
    @(posedge clk); #2;
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    regnum = a; regdata_write = d; reg_write = 1'b1;
    cyc();
    reg_write = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [6:0] a, input logic [7:0] exp);
    regnum = a; reg_write = 1'b0;
    #1;
    chk(nm, regdata_read, exp);
    cyc();
  endtask

  function automatic logic probe(input int which);
    case (which)
      0: return tx_avail;
      1: return rx_arm;
      default: return oe;
    endcase
  endfunction

  task automatic wait_for(input int which, input string nm);
    int g = 0;
    while (!probe(which) && g < 400) begin cyc(); g++; end
    if (g >= 400) begin
      checks++; errors++;
      $display("FAIL %s: wait expired, got 0 required 1", nm);
    end
  endtask

  task automatic run_wait(input int rx_at, output int n);
    int g = 0;
    n = 0;
    while (rx_arm && g < 2000) begin
      tick = ($urandom % 2 == 0);
      if (tick) n++;
      rx_done = (rx_at != 0) && tick && (n == rx_at);
      cyc(); g++;
    end
    tick = 1'b0; rx_done = 1'b0;
    if (g >= 2000) begin
      checks++; errors++;
      $display("FAIL rxwait_bound: got still waiting required exit");
    end
  endtask

  initial begin : main
    int ns, ne, n, g;
    logic [6:0] rsel;
    logic [7:0] ctrl_tab [8];
    ctrl_tab = '{8'h01, 8'h05, 8'h01, 8'h05, 8'h02, 8'h03, 8'h07, 8'h04};
    rst = 1'b1; reg_write = 1'b0; regnum = 7'd0; regdata_write = 8'h00;
    tick = 1'b0; rx_done = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;
    cyc();

    rd_chk("rst_reg0", 7'd0, 8'hA7);
    rd_chk("rst_reg1", 7'd1, 8'h00);
    rd_chk("rst_reg2", 7'd2, 8'h06);
    rd_chk("rst_reg3", 7'd3, 8'h00);
    rd_chk("rst_reg4", 7'd4, 8'h00);
    rd_chk("rst_reg5", 7'd5, 8'h00);
    rd_chk("rst_reg6", 7'd6, 8'hFF);
    rd_chk("rst_reg7", 7'd7, 8'h00);
    rd_chk("rst_reg9", 7'd9, 8'hFF);

    wr(7'd3, 8'h03);
    rd_chk("portsel_3", 7'd3, 8'h03);
    wr(7'd3, 8'h04);
    rd_chk("portsel_oob", 7'd3, 8'h03);

    // plain transaction, no response; PORTSEL write while busy
    wr(7'd7, 8'h01);
    wait_for(0, "avail_t3");
    wr(7'd4, 8'h01);
    ns = 0; ne = 0; g = 0;
    while (busy && g < 400) begin
      if (trigger_start) ns++;
      if (trigger_end) ne++;
      if (g == 0) begin regnum = 7'd3; regdata_write = 8'h01; reg_write = 1'b1; end
      else reg_write = 1'b0;
      cyc(); g++;
    end
    reg_write = 1'b0;
    chk("start_pulses", 8'(ns), 8'd1);
    chk("end_pulses", 8'(ne), 8'd1);
    chk("irq_before", 8'(irq), 8'd0);
    rd_chk("status_done", 7'd5, 8'h01);
    chk("irq_after", 8'(irq), 8'd1);
    rd_chk("portsel_busy", 7'd3, 8'h03);
    wr(7'd5, 8'h07);

    // abort during data
    wait_for(0, "avail_t7");
    wr(7'd4, 8'h01);
    wait_for(2, "oe_t7");
    cyc();
    wr(7'd4, 8'h02);
    chk("abort_flush", 8'(tx_flush), 8'd1);
    chk("abort_busy", 8'(busy), 8'd0);
    rd_chk("status_aborted", 7'd5, 8'h04);
    wr(7'd5, 8'h04);
    rd_chk("status_w1c", 7'd5, 8'h00);

    // GO and ABORT together from idle
    wait_for(0, "avail_t8");
    wr(7'd4, 8'h03);
    chk("goab_start", 8'(trigger_start), 8'd0);
    chk("goab_flush", 8'(tx_flush), 8'd1);
    chk("goab_busy", 8'(busy), 8'd0);
    rd_chk("goab_status", 7'd5, 8'h00);

    // response wait: timeout, rx_done at tick 31, rx_done on the expiring tick
    wr(7'd6, 8'h02);
    wait_for(0, "avail_t4");
    wr(7'd4, 8'h05);
    wait_for(1, "rxarm_t4");
    run_wait(0, n);
    chk("timeout_ticks", 8'(n), 8'd32);
    rd_chk("status_timeout", 7'd5, 8'h02);
    wr(7'd5, 8'h07);

    wait_for(0, "avail_t5");
    wr(7'd4, 8'h05);
    wait_for(1, "rxarm_t5");
    run_wait(31, n);
    chk("rx31_ticks", 8'(n), 8'd31);
    rd_chk("status_rx31", 7'd5, 8'h01);
    wr(7'd5, 8'h07);

    wait_for(0, "avail_t6");
    wr(7'd4, 8'h05);
    wait_for(1, "rxarm_t6");
    run_wait(32, n);
    chk("coinc_ticks", 8'(n), 8'd32);
    rd_chk("status_coinc", 7'd5, 8'h01);
    chk("irq_pending", 8'(irq), 8'd1);

    // reset while waiting for a response
    wait_for(0, "avail_t9");
    wr(7'd4, 8'h05);
    wait_for(1, "rxarm_t9");
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_rx_arm", 8'(rx_arm), 8'd0);
    chk("rst_tstart", 8'(trigger_start), 8'd0);
    chk("rst_tend", 8'(trigger_end), 8'd0);
    chk("rst_flush", 8'(tx_flush), 8'd0);
    chk("rst_irq", 8'(irq), 8'd0);
    chk("rst_portsel", 8'(port_select), 8'd0);
    chk("rst_clkdiv", clock_div, 8'h06);
    rd_chk("rst_status", 7'd5, 8'h00);

    // randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      tick    = ($urandom % 3 == 0);
      rx_done = ($urandom % 50 == 0);
      rst     = ($urandom % 800 == 0);
      n = int'($urandom % 14);
      if (n < 8) rsel = 7'(n);
      else if (n < 12) rsel = 7'd4;
      else rsel = 7'(9 + ($urandom % 100));
      regnum = rsel;
      reg_write = ($urandom % 5 == 0);
      case (rsel)
        7'd4: regdata_write = ctrl_tab[$urandom % 8];
        7'd6: regdata_write = 8'($urandom % 4);
        7'd3: regdata_write = 8'($urandom % 6);
        default: regdata_write = 8'($urandom);
      endcase
      cyc();
    end
    rst = 1'b0; reg_write = 1'b0; tick = 1'b0; rx_done = 1'b0;
    repeat (3) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
